// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a comparator's trial operand
// MSB-first and builds the target from its alb/aeb/agb answers. Define
// SAR_EARLY_EXIT_EN to end the search as soon as the comparator reports equality.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             alb,
  input  logic             aeb,
  input  logic             agb,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MASK_TOP = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             flags_onehot;
  logic             finish;

  assign flags_onehot = ({alb, aeb, agb} == 3'b100) ||
                        ({alb, aeb, agb} == 3'b010) ||
                        ({alb, aeb, agb} == 3'b001);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // with result/err valid from that cycle until the next accepted start.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    result_d = result_q;
    err_d    = err_q;
    trial_d  = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mask_d   = MASK_TOP;
          result_d = '0;
          err_d    = 1'b0;
          state_d  = TEST;
          trial_d  = MASK_TOP;
          busy_d   = 1'b1;
        end
      end
      TEST: begin
        if (!flags_onehot) begin
          err_d    = 1'b1;
          result_d = acc_q;
          finish   = 1'b1;
        end else begin
          // Trial at or below the target: the bit under test belongs to it.
          if (alb || aeb) acc_d = acc_q | mask_q;
`ifdef SAR_EARLY_EXIT_EN
          if (aeb || mask_q[0]) begin
            result_d = acc_d;
            finish   = 1'b1;
          end
`else
          if (mask_q[0]) begin
            result_d = acc_d;
            finish   = 1'b1;
          end
`endif
          if (!finish) begin
            mask_d  = mask_q >> 1;
            trial_d = acc_d | (mask_q >> 1);
            busy_d  = 1'b1;
          end
        end
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      trial_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign trial     = trial_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural comparator closes the loop, and a per-cycle
// expected-output queue derived from the target's binary expansion is checked on negedges.
module tb_sar_search;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         alb, aeb, agb;
  logic [W-1:0] trial;
  logic         busy, done, err;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  logic [W-1:0] target;
  logic         flag_force;
  logic [W-1:0] last_res;
  logic         last_err;
  exp_t         exp_q[$];
  int           n_checks;
  int           n_fail;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alb(alb), .aeb(aeb), .agb(agb),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .err(err), .dbg_state(dbg_state)
  );

  // Comparator model: a = trial, b = target; forcing drives all flags low.
  assign {alb, aeb, agb} = flag_force ? 3'b000 :
                           {trial < target, trial == target, trial > target};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Bits of the target strictly above the bit tested at step i.
  function automatic logic [W-1:0] accepted(input logic [W-1:0] tgt, input int i);
    int span;
    int v;
    span = 1 << (W - i);
    v = int'(tgt) & ~(span - 1);
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] exp_trial(input logic [W-1:0] tgt, input int i);
    int v;
    v = int'(accepted(tgt, i)) | (1 << (W - 1 - i));
    return v[W-1:0];
  endfunction

  function automatic exp_t mk(input logic [W-1:0] t, input logic b, input logic d,
                              input logic [W-1:0] r, input logic e);
    exp_t x;
    x.trial = t; x.busy = b; x.done = d; x.result = r; x.err = e;
    return x;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("trial",  32'(trial),  32'(e.trial));
      check("busy",   32'(busy),   32'(e.busy));
      check("done",   32'(done),   32'(e.done));
      check("result", 32'(result), 32'(e.result));
      check("err",    32'(err),    32'(e.err));
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(mk('0, 1'b0, 1'b0, last_res, last_err));
    end
  endtask

  // One search; returns at #1 into the done cycle. fault_at forces flags 000 on that step.
  task automatic run_search(input logic [W-1:0] tgt, input int fault_at,
                            input bit mid_start, input bit hold);
    logic [W-1:0] res;
    logic         e;
    bit           ended;
    @(posedge clk); #1;
    target = tgt;
    start  = 1'b1;
    exp_q.push_back(mk('0, 1'b0, 1'b0, last_res, last_err));
    res = tgt;
    e = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < W && !ended; i++) begin
      @(posedge clk); #1;
      if (!hold) start = mid_start && (i == 1);
      exp_q.push_back(mk(exp_trial(tgt, i), 1'b1, 1'b0, '0, 1'b0));
      if (i == fault_at) begin
        flag_force = 1'b1;
        res = accepted(tgt, i);
        e = 1'b1;
        ended = 1'b1;
      end
`ifdef SAR_EARLY_EXIT_EN
      else if (exp_trial(tgt, i) == tgt) ended = 1'b1;
`endif
    end
    @(posedge clk); #1;
    flag_force = 1'b0;
    if (!hold) start = 1'b0;
    exp_q.push_back(mk('0, 1'b0, 1'b1, res, e));
    last_res = res;
    last_err = e;
  endtask

  task automatic reset_mid(input logic [W-1:0] tgt);
    @(posedge clk); #1;
    target = tgt;
    start  = 1'b1;
    exp_q.push_back(mk('0, 1'b0, 1'b0, last_res, last_err));
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(mk(exp_trial(tgt, 0), 1'b1, 1'b0, '0, 1'b0));
    @(posedge clk); #1;
    exp_q.push_back(mk(exp_trial(tgt, 1), 1'b1, 1'b0, '0, 1'b0));
    @(posedge clk); #1;
    exp_q.push_back(mk('0, 1'b0, 1'b0, '0, 1'b0));
    rst = 1'b1;
    #1;
    check("rst_mid_trial", 32'(trial), 0);
    check("rst_mid_busy",  32'(busy),  0);
    check("rst_mid_done",  32'(done),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    last_err = 1'b0;
    exp_q.push_back(mk('0, 1'b0, 1'b0, '0, 1'b0));
    idle_cycles(3);
  endtask

  initial begin
    logic [W-1:0] lit [4];
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    target     = '0;
    flag_force = 1'b0;
    last_res   = '0;
    last_err   = 1'b0;
    #2;
    check("reset_trial",  32'(trial),  0);
    check("reset_busy",   32'(busy),   0);
    check("reset_done",   32'(done),   0);
    check("reset_result", 32'(result), 0);
    check("reset_err",    32'(err),    0);

    lit[0] = 4'd8; lit[1] = 4'd12; lit[2] = 4'd10; lit[3] = 4'd11;
    for (int i = 0; i < W; i++) check("model_trial_t10", 32'(exp_trial(4'd10, i)), 32'(lit[i]));
    lit[0] = 4'd8; lit[1] = 4'd4; lit[2] = 4'd2; lit[3] = 4'd1;
    for (int i = 0; i < W; i++) check("model_trial_t0", 32'(exp_trial(4'd0, i)), 32'(lit[i]));

    @(posedge clk); #1;
    rst = 1'b0;

    run_search(4'd10, -1, 1'b0, 1'b0);
    check("t10_result", 32'(result), 10);
    check("t10_err",    32'(err),    0);
    run_search(4'd0, -1, 1'b0, 1'b0);
    check("t0_result", 32'(result), 0);
    run_search(4'd15, -1, 1'b0, 1'b0);
    check("t15_result", 32'(result), 15);
    run_search(4'd10, 1, 1'b0, 1'b0);
    check("fault_result", 32'(result), 8);
    check("fault_err",    32'(err),    1);
    idle_cycles(1);

    reset_mid(4'd6);
    run_search(4'd6, -1, 1'b0, 1'b0);
    check("after_rst_result", 32'(result), 6);

    run_search(4'd9, -1, 1'b1, 1'b0);
    idle_cycles(3);

    run_search(4'd5, -1, 1'b0, 1'b1);
    run_search(4'd12, -1, 1'b0, 1'b1);
    run_search(4'd3, -1, 1'b0, 1'b0);
    check("held_last_result", 32'(result), 3);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] tgt;
      int fa;
      tgt = W'($urandom_range(0, (1 << W) - 1));
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_search(tgt, fa, 1'($urandom_range(0, 1)), 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(2);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
